voting_machine: RTL and testbench

- Four-candidate electronic voting machine with a single clock.
- In vote mode (mode=0), a held, debounced, single-button press registers one vote for that candidate, and the LEDs flash all-on for one cycle.
- In result mode (mode=1), the LEDs show the stored vote count of the candidate whose button is held.
- Top-level leaf block driving an 8-LED display bank.

---
 rtl/voting_pkg.sv | 34 +++
 rtl/press_qualifier.sv | 80 ++++++++
 rtl/voting_machine.sv | 73 +++++++
 tb/tb_voting_machine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared definitions for the four-candidate voting machine.
// Holds candidate count, default timing/width constants, the LED flash
// pattern, mode encodings and two small button-vector helpers used by both
// the press qualifier and the display mux.
package voting_pkg;

  localparam int NUM_CAND    = 4;
  localparam int ID_W        = $clog2(NUM_CAND);
  localparam int HOLD_CYCLES = 10;
  localparam int CNT_W       = 8;

  localparam logic [7:0] LED_FLASH   = 8'hFF;
  localparam logic       MODE_VOTE   = 1'b0;
  localparam logic       MODE_RESULT = 1'b1;

  typedef logic [ID_W-1:0] cand_id_t;

  // True when exactly one button of the vector is high.
  function automatic logic is_single(input logic [NUM_CAND-1:0] b);
    return (b != '0) && ((b & (b - 1'b1)) == '0);
  endfunction

  // Index of the lowest-numbered high button (button1 has top priority).
  // Returns 0 for an all-zero vector; callers qualify with |b or is_single.
  function automatic cand_id_t first_set(input logic [NUM_CAND-1:0] b);
    cand_id_t idx;
    idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (b[i]) idx = cand_id_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/press_qualifier.sv
// Press qualifier: turns raw level buttons into at most one vote per
// distinct press.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mode       0 = vote mode, 1 = result mode (qualification disabled)
//   buttons    button vector, bit 0 = button1
//   vote_valid one-cycle pulse, registered, on the edge a press is accepted
//   vote_id    candidate index of the accepted press (valid with vote_valid)
// A press is accepted when the same single button has been seen on
// HOLD_CYCLES consecutive edges; it then locks until released or replaced
// by a different single button.
module press_qualifier #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [3:0] buttons,
  output logic       vote_valid,
  output logic [1:0] vote_id
);
  import voting_pkg::*;

  localparam logic [7:0] HOLD_TGT = 8'(HOLD_CYCLES);

  logic [7:0] hcnt_q, hcnt_d;
  cand_id_t   id_q, id_d, press_id;
  logic       locked_q, locked_d;
  logic       valid_q, valid_d;

  assign press_id = first_set(buttons);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    hcnt_d   = hcnt_q;
    id_d     = id_q;
    locked_d = locked_q;
    valid_d  = 1'b0;

    if (mode == MODE_RESULT || !is_single(buttons)) begin
      // Release, chord or result mode: start over and drop the lock.
      hcnt_d   = '0;
      locked_d = 1'b0;
    end else if (press_id != id_q) begin
      hcnt_d   = 8'd1;
      id_d     = press_id;
      locked_d = 1'b0;
    end else if (!locked_q) begin
      hcnt_d = hcnt_q + 8'd1;
    end

    // A cleared count is never equal to the target (HOLD_CYCLES >= 1), and a
    // locked press keeps locked_d high, so this fires once per press.
    if (!locked_d && hcnt_d == HOLD_TGT) begin
      valid_d  = 1'b1;
      locked_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q   <= '0;
      id_q     <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      id_q     <= id_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
    end
  end

  assign vote_valid = valid_q;
  assign vote_id    = id_q;

endmodule

// File: rtl/voting_machine.sv
// Four-candidate voting machine top.
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   mode            0 = vote mode, 1 = result/display mode
//   button1..4      candidate buttons, active-high levels
//   led             registered display: all-on for one cycle per accepted
//                   vote (mode 0) or the count of the highest-priority held
//                   button (mode 1)
// Holds the per-candidate saturating counters and the LED mux/register;
// press qualification lives in press_qualifier.
module voting_machine #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             button1,
  input  logic             button2,
  input  logic             button3,
  input  logic             button4,
  output logic [CNT_W-1:0] led
);
  import voting_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CAND-1:0] buttons;
  logic                vote_valid;
  cand_id_t            vote_id;
  logic [CNT_W-1:0]    count [NUM_CAND];
  logic [CNT_W-1:0]    led_d;

  assign buttons = {button4, button3, button2, button1};

  press_qualifier #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_press_qualifier (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .buttons   (buttons),
    .vote_valid(vote_valid),
    .vote_id   (vote_id)
  );

  // NOTE: the counters are a small flop array, not a RAM, so they take the
  // asynchronous reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
    end else if (vote_valid && count[vote_id] != CNT_MAX) begin
      count[vote_id] <= count[vote_id] + CNT_W'(1);
    end
  end

  // Display uses the pre-increment count, so a vote accepted on this edge
  // shows up in mode 1 one cycle later.
  always_comb begin
    led_d = '0;
    if (mode == MODE_RESULT) begin
      if (|buttons) led_d = count[first_set(buttons)];
    end else if (vote_valid) begin
      led_d = CNT_W'(LED_FLASH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led <= '0;
    else      led <= led_d;
  end

endmodule

// File: tb/tb_voting_machine.sv
// Self-checking bench for voting_machine: a table of directed hold/release
// vectors with constant expectations, hand-written reset and saturation
// sequences, and randomized holds compared cycle by cycle against a
// run-length reference model.
module tb_voting_machine;

  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
  logic [7:0] led;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: run length of the current single press, pending vote,
  // per-candidate counts and the expected LED value after each edge.
  int  run_len;
  int  run_id;
  bit  pend;
  int  pend_id;
  int  cnt [4];
  int  led_exp;

  voting_machine #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .button1(button1),
    .button2(button2),
    .button3(button3),
    .button4(button4),
    .led    (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int prio(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    run_len = 0; run_id = 0; pend = 0; pend_id = 0; led_exp = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  // One rising edge with inputs (m, b).
  task automatic model_edge(input logic m, input logic [3:0] b);
    int nl;
    int p;
    p = prio(b);
    if (m) nl = (p < 0) ? 0 : cnt[p];
    else   nl = pend ? 255 : 0;
    if (pend && cnt[pend_id] < 255) cnt[pend_id]++;
    pend = 0;
    if (m || $countones(b) != 1) begin
      run_len = 0;
    end else begin
      if (run_len > 0 && p == run_id) run_len++;
      else begin run_len = 1; run_id = p; end
      if (run_len == HOLD) begin pend = 1; pend_id = p; end
    end
    led_exp = nl;
  endtask

  task automatic step(input logic m, input logic [3:0] b, input string name);
    @(negedge clk);
    mode = m;
    {button4, button3, button2, button1} = b;
    @(posedge clk);
    model_edge(m, b);
    #1 check(name, {24'b0, led}, led_exp);
  endtask

  task automatic hold(input logic m, input logic [3:0] b, input int n, input string name,
                      output int flashes, output int first_at);
    flashes = 0; first_at = 0;
    for (int i = 1; i <= n; i++) begin
      step(m, b, name);
      if (!m && led === 8'hFF) begin
        flashes++;
        if (first_at == 0) first_at = i;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic       m;
    logic [3:0] b;
    int         cycles;
    int         exp_flashes;
    logic [7:0] exp_last;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int fl, fa, total;
    logic [3:0] pat;
    logic       m;

    // Directed vectors, applied in order; counts accumulate across them.
    tbl.push_back('{"idle",          1'b0, 4'b0000, 10, 0, 8'd0});
    tbl.push_back('{"res_b1_empty",  1'b1, 4'b0001,  2, 0, 8'd0});
    tbl.push_back('{"res_b2_empty",  1'b1, 4'b0010,  2, 0, 8'd0});
    tbl.push_back('{"res_b3_empty",  1'b1, 4'b0100,  2, 0, 8'd0});
    tbl.push_back('{"res_b4_empty",  1'b1, 4'b1000,  2, 0, 8'd0});
    tbl.push_back('{"vote_b1",       1'b0, 4'b0001, 20, 1, 8'd0});
    tbl.push_back('{"rel1",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"short_b1",      1'b0, 4'b0001,  5, 0, 8'd0});
    tbl.push_back('{"rel2",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"res_b1_1",      1'b1, 4'b0001,  2, 0, 8'd1});
    tbl.push_back('{"vote_b2_a",     1'b0, 4'b0010, 20, 1, 8'd0});
    tbl.push_back('{"rel3",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"vote_b2_b",     1'b0, 4'b0010, 20, 1, 8'd0});
    tbl.push_back('{"rel4",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"res_b2_2",      1'b1, 4'b0010,  2, 0, 8'd2});
    tbl.push_back('{"chord_b2b3",    1'b0, 4'b0110, 20, 0, 8'd0});
    tbl.push_back('{"res_b2_still2", 1'b1, 4'b0010,  2, 0, 8'd2});
    tbl.push_back('{"res_b3_0",      1'b1, 4'b0100,  2, 0, 8'd0});
    tbl.push_back('{"vote_b3_a",     1'b0, 4'b0100, 12, 1, 8'd0});
    tbl.push_back('{"rel5",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"vote_b3_b",     1'b0, 4'b0100, 12, 1, 8'd0});
    tbl.push_back('{"rel6",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"res_b3_2",      1'b1, 4'b0100,  2, 0, 8'd2});
    tbl.push_back('{"res_prio_b2b3", 1'b1, 4'b0110,  2, 0, 8'd2});
    tbl.push_back('{"res_hold_b4",   1'b1, 4'b1000, 20, 0, 8'd0});
    tbl.push_back('{"res_hold_b3",   1'b1, 4'b0100, 20, 0, 8'd2});
    tbl.push_back('{"res_prio_all",  1'b1, 4'b1111,  2, 0, 8'd1});
    tbl.push_back('{"midhold_a",     1'b0, 4'b0001,  6, 0, 8'd0});
    tbl.push_back('{"midhold_mode",  1'b1, 4'b0001,  1, 0, 8'd1});
    tbl.push_back('{"midhold_b",     1'b0, 4'b0001,  6, 0, 8'd0});
    tbl.push_back('{"rel7",          1'b0, 4'b0000,  1, 0, 8'd0});
    tbl.push_back('{"res_b1_still1", 1'b1, 4'b0001,  2, 0, 8'd1});
    tbl.push_back('{"vote_b1_sw",    1'b0, 4'b0001, 12, 1, 8'd0});
    tbl.push_back('{"switch_b2",     1'b0, 4'b0010, 12, 1, 8'd0});
    tbl.push_back('{"res_b1_2",      1'b1, 4'b0001,  2, 0, 8'd2});
    tbl.push_back('{"res_b2_3",      1'b1, 4'b0010,  2, 0, 8'd3});

    // Reset held for 10 cycles.
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("in_reset", {24'b0, led}, 0);
    end
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k]) begin
      hold(tbl[k].m, tbl[k].b, tbl[k].cycles, tbl[k].name, fl, fa);
      check({tbl[k].name, "_flashes"}, fl, tbl[k].exp_flashes);
      if (tbl[k].exp_flashes == 1) check({tbl[k].name, "_flash_cycle"}, fa, HOLD + 1);
      check({tbl[k].name, "_last"}, {24'b0, led}, {24'b0, tbl[k].exp_last});
    end

    // Reset mid-hold: no partial vote survives.
    hold(1'b0, 4'b1000, 7, "pre_reset_b4", fl, fa);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check("midhold_reset_led", {24'b0, led}, 0);
    @(negedge clk);
    rst = 1'b1;
    hold(1'b0, 4'b1000, 5, "post_reset_b4", fl, fa);
    check("post_reset_b4_flashes", fl, 0);
    hold(1'b0, 4'b0000, 1, "rel8", fl, fa);
    hold(1'b1, 4'b1000, 2, "res_b4_after_reset", fl, fa);
    check("res_b4_after_reset", {24'b0, led}, 0);
    hold(1'b1, 4'b0001, 2, "res_b1_after_reset", fl, fa);
    check("res_b1_after_reset", {24'b0, led}, 0);

    // Saturation: 260 accepted votes on button4.
    total = 0;
    for (int v = 0; v < 260; v++) begin
      hold(1'b0, 4'b1000, HOLD + 1, "sat_b4", fl, fa);
      total += fl;
      hold(1'b0, 4'b0000, 1, "sat_rel", fl, fa);
    end
    check("sat_flashes", total, 260);
    hold(1'b1, 4'b1000, 2, "res_b4_sat", fl, fa);
    check("res_b4_sat", {24'b0, led}, 255);

    // Asynchronous reset between edges while the display shows 255.
    #2 rst = 1'b0;
    model_reset();
    #1 check("async_reset_led", {24'b0, led}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pat = 4'b0001 << i;
      hold(1'b1, pat, 2, "res_cleared", fl, fa);
      check("res_cleared", {24'b0, led}, 0);
    end

    // Randomized holds checked against the model every cycle.
    for (int s = 0; s < 600; s++) begin
      m = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 7) pat = 4'b0001 << $urandom_range(0, 3);
      else                          pat = 4'($urandom_range(0, 15));
      hold(m, pat, $urandom_range(1, 14), "random", fl, fa);
    end
    for (int i = 0; i < 4; i++) begin
      pat = 4'b0001 << i;
      hold(1'b1, pat, 1, "random_final_count", fl, fa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
